// File: rtl/thermo_plant.sv
// thermo_plant: closed-loop thermal plant and actuator model.
// Consumes the thermostat heat/cool commands, runs a heater/cooler FSM with a
// forced dead time after every switch-off, and steps the actual temperature
// once per prescaler tick with saturation at T_MIN/T_MAX.
// Optional ambient drift in IDLE/DEAD is enabled by defining THERMO_PLANT_DRIFT_EN.
module thermo_plant #(
  parameter int               WIDTH     = 8,
  parameter int               STEP_DIV  = 16,
  parameter int               DEAD_TIME = 4,
  parameter logic [WIDTH-1:0] T_INIT    = 8'd20,
  parameter logic [WIDTH-1:0] T_MIN     = 8'd0,
  parameter logic [WIDTH-1:0] T_MAX     = 8'd255,
  parameter logic [WIDTH-1:0] T_AMB     = 8'd20,
  parameter int               DRIFT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      Hon,
  input  logic [11:0]      Con,
  output logic [WIDTH-1:0] Tact,
  output logic             heating,
  output logic             cooling,
  output logic             fault,
  output logic             tick
);

  localparam int PW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DEAD_TIME + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAT = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  logic          req_h;
  logic          req_c;
  logic          conflict;
  logic [PW-1:0] pre_cnt;
  logic          tick_int;
  logic [DW-1:0] dead_cnt;
  logic [1:0]    state;
  logic [1:0]    next_state;

  assign req_h    = (|Hon) & ~(|Con);
  assign req_c    = (|Con) & ~(|Hon);
  assign conflict = (|Hon) & (|Con);
  assign tick_int = (pre_cnt == PW'(STEP_DIV - 1));

  // Free-running prescaler; tick_int marks the last count of each period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick_int) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Next-state decode; DEAD ignores commands until its tick budget runs out
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_h) begin
          next_state = S_HEAT;
        end else if (req_c) begin
          next_state = S_COOL;
        end
      end
      S_HEAT: begin
        if (!req_h) begin
          next_state = S_DEAD;
        end
      end
      S_COOL: begin
        if (!req_c) begin
          next_state = S_DEAD;
        end
      end
      S_DEAD: begin
        if (tick_int && (dead_cnt == DW'(1))) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dead-time counter: loaded on entry to DEAD, counts down on internal ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if ((state != S_DEAD) && (next_state == S_DEAD)) begin
      dead_cnt <= DW'(DEAD_TIME);
    end else if ((state == S_DEAD) && tick_int) begin
      dead_cnt <= dead_cnt - DW'(1);
    end
  end

  // Registered status outputs, taken from the state being entered so they
  // line up with the state register (one clock after the command)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heating <= 1'b0;
      cooling <= 1'b0;
      fault   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      heating <= (next_state == S_HEAT);
      cooling <= (next_state == S_COOL);
      fault   <= conflict;
      tick    <= tick_int;
    end
  end

`ifdef THERMO_PLANT_DRIFT_EN
  localparam int DRW = $clog2(DRIFT_DIV + 1);

  logic [DRW-1:0] drift_cnt;
  logic           drift_due;
  logic           passive;

  assign passive   = (state == S_IDLE) || (state == S_DEAD);
  assign drift_due = passive && (drift_cnt == DRW'(DRIFT_DIV - 1));

  // Drift counter counts ticks while passive and restarts on entering HEAT/COOL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drift_cnt <= '0;
    end else if (((next_state == S_HEAT) || (next_state == S_COOL)) &&
                 (state != S_HEAT) && (state != S_COOL)) begin
      drift_cnt <= '0;
    end else if (tick_int && passive) begin
      if (drift_due) begin
        drift_cnt <= '0;
      end else begin
        drift_cnt <= drift_cnt + DRW'(1);
      end
    end
  end

  // Temperature step on tick; passive states drift toward ambient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Tact <= T_INIT;
    end else if (tick_int) begin
      if ((state == S_HEAT) && (Tact < T_MAX)) begin
        Tact <= Tact + WIDTH'(1);
      end else if ((state == S_COOL) && (Tact > T_MIN)) begin
        Tact <= Tact - WIDTH'(1);
      end else if (drift_due && (Tact < T_AMB)) begin
        Tact <= Tact + WIDTH'(1);
      end else if (drift_due && (Tact > T_AMB)) begin
        Tact <= Tact - WIDTH'(1);
      end
    end
  end
`else
  logic unused_drift_cfg;
  assign unused_drift_cfg = ^{T_AMB, DRIFT_DIV};

  // Temperature step on tick using the state held before the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Tact <= T_INIT;
    end else if (tick_int) begin
      if ((state == S_HEAT) && (Tact < T_MAX)) begin
        Tact <= Tact + WIDTH'(1);
      end else if ((state == S_COOL) && (Tact > T_MIN)) begin
        Tact <= Tact - WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_thermo_plant.sv
// tb_thermo_plant: directed plus randomized bench for thermo_plant with a
// behavioural plant model (ticks counted from reset, dead time in ticks).
module tb_thermo_plant;

  localparam int STEP_DIV  = 16;
  localparam int DEAD_TIME = 4;
  localparam int T_INIT    = 20;
  localparam int T_MIN     = 0;
  localparam int T_MAX     = 255;
  localparam int T_AMB     = 20;
  localparam int DRIFT_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] hon = '0;
  logic [11:0] con = '0;
  logic [7:0]  tact;
  logic        heating;
  logic        cooling;
  logic        fault;
  logic        tick;

  int checks = 0;
  int failures = 0;

  // behavioural model: mode names, cycles since reset release, ticks left in dead time
  typedef enum int {M_IDLE, M_HEAT, M_COOL, M_DEAD} mode_t;
  mode_t m_mode;
  int    m_cyc;
  int    m_dead_left;
  int    m_temp;
  int    m_drift;
  bit    m_tick;
  bit    m_fault;

  thermo_plant #(
    .WIDTH(8), .STEP_DIV(STEP_DIV), .DEAD_TIME(DEAD_TIME),
    .T_INIT(8'(T_INIT)), .T_MIN(8'(T_MIN)), .T_MAX(8'(T_MAX)),
    .T_AMB(8'(T_AMB)), .DRIFT_DIV(DRIFT_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Hon(hon), .Con(con),
    .Tact(tact), .heating(heating), .cooling(cooling),
    .fault(fault), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_cyc       = 0;
    m_dead_left = 0;
    m_temp      = T_INIT;
    m_drift     = 0;
    m_tick      = 0;
    m_fault     = 0;
  endtask

  // advance the model by one clock edge with the given commands
  task automatic model_edge(input logic [11:0] h, input logic [11:0] c);
    bit want_heat;
    bit want_cool;
    want_heat = (h != 0) && (c == 0);
    want_cool = (c != 0) && (h == 0);
    m_cyc++;
    m_tick  = (m_cyc % STEP_DIV) == 0;
    m_fault = (h != 0) && (c != 0);
    if (m_tick) begin
      if (m_mode == M_HEAT) begin
        if (m_temp < T_MAX) m_temp++;
      end else if (m_mode == M_COOL) begin
        if (m_temp > T_MIN) m_temp--;
      end else begin
`ifdef THERMO_PLANT_DRIFT_EN
        m_drift++;
        if (m_drift == DRIFT_DIV) begin
          m_drift = 0;
          if (m_temp < T_AMB) m_temp++;
          else if (m_temp > T_AMB) m_temp--;
        end
`endif
      end
      if (m_mode == M_DEAD) m_dead_left--;
    end
    case (m_mode)
      M_IDLE: begin
        if (want_heat) begin m_mode = M_HEAT; m_drift = 0; end
        else if (want_cool) begin m_mode = M_COOL; m_drift = 0; end
      end
      M_HEAT: if (!want_heat) begin m_mode = M_DEAD; m_dead_left = DEAD_TIME; end
      M_COOL: if (!want_cool) begin m_mode = M_DEAD; m_dead_left = DEAD_TIME; end
      M_DEAD: if (m_dead_left == 0) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_output();
    check_val("tact", 32'(tact), 32'(m_temp));
    check_val("heating", 32'(heating), 32'(m_mode == M_HEAT));
    check_val("cooling", 32'(cooling), 32'(m_mode == M_COOL));
    check_val("fault", 32'(fault), 32'(m_fault));
    check_val("tick", 32'(tick), 32'(m_tick));
  endtask

  // called at a negedge; drives commands for n clocks, checking after each edge
  task automatic apply_stimulus(input logic [11:0] h, input logic [11:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      hon = h;
      con = c;
      model_edge(h, c);
      @(posedge clk);
      #1;
      check_output();
      @(negedge clk);
    end
  endtask

  // called between edges; asserts reset, checks it, releases at a later negedge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] thermo_plant bench start");
    model_reset();

    // reset held with a heat command present
    hon = 12'h001;
    con = 12'h000;
    repeat (3) @(negedge clk);
    check_val("rst_tact", 32'(tact), 32'd20);
    check_val("rst_heating", 32'(heating), 32'd0);
    check_val("rst_cooling", 32'(cooling), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    apply_stimulus(12'h001, 12'h000, 1);
    check_val("rel_heating", 32'(heating), 32'd1);
    apply_stimulus(12'h001, 12'h000, 14);
    check_val("pre_tick_tact", 32'(tact), 32'd20);
    apply_stimulus(12'h001, 12'h000, 1);
    check_val("first_tick", 32'(tick), 32'd1);
    check_val("first_tick_tact", 32'(tact), 32'd21);

    // cool for three ticks, then request heat through the dead time
    do_reset();
    apply_stimulus(12'h000, 12'h010, 48);
    check_val("cool_tact", 32'(tact), 32'd17);
    apply_stimulus(12'h020, 12'h000, 1);
    check_val("dead_cooling", 32'(cooling), 32'd0);
    check_val("dead_heating", 32'(heating), 32'd0);
    apply_stimulus(12'h020, 12'h000, 63);
    check_val("dead_end_heating", 32'(heating), 32'd0);
    check_val("dead_hold_tact", 32'(tact), 32'd17);
    apply_stimulus(12'h020, 12'h000, 1);
    check_val("post_dead_heating", 32'(heating), 32'd1);
    apply_stimulus(12'h020, 12'h000, 15);
    check_val("post_dead_tact", 32'(tact), 32'd18);

    // conflict from IDLE, then clear the cool command
    do_reset();
    apply_stimulus(12'h001, 12'h800, 3);
    check_val("conflict_fault", 32'(fault), 32'd1);
    check_val("conflict_heating", 32'(heating), 32'd0);
    apply_stimulus(12'h001, 12'h000, 1);
    check_val("clear_fault", 32'(fault), 32'd0);
    check_val("clear_heating", 32'(heating), 32'd1);

    // heat into upper saturation, then cool into lower saturation
    do_reset();
    apply_stimulus(12'hFFF, 12'h000, 240 * STEP_DIV);
    check_val("sat_high", 32'(tact), 32'd255);
    apply_stimulus(12'h000, 12'h400, 270 * STEP_DIV);
    check_val("sat_low", 32'(tact), 32'd0);

    // asynchronous reset while in DEAD
    do_reset();
    apply_stimulus(12'h004, 12'h000, 20);
    apply_stimulus(12'h000, 12'h000, 10);
    #2;
    do_reset();
    check_val("async_tact", 32'(tact), 32'd20);
    apply_stimulus(12'h004, 12'h000, 1);
    check_val("async_no_dead", 32'(heating), 32'd1);

    // randomized command segments against the model
    for (int s = 0; s < 40; s++) begin
      int          kind;
      int          len;
      logic [11:0] pat_h;
      logic [11:0] pat_c;
      kind  = $urandom_range(0, 3);
      len   = $urandom_range(1, 80);
      pat_h = 12'($urandom_range(1, 4095));
      pat_c = 12'($urandom_range(1, 4095));
      case (kind)
        0:       apply_stimulus(12'h000, 12'h000, len);
        1:       apply_stimulus(pat_h, 12'h000, len);
        2:       apply_stimulus(12'h000, pat_c, len);
        default: apply_stimulus(pat_h, pat_c, len);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
